// File: rtl/interface_arb_pkg.sv
// Shared types and defaults for interface_arbiter and its round-robin picker.
package interface_arb_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int MAX_BURST_DEF = 8;
  localparam int BEAT_CNT_W    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/interface_arbiter_rr_pick.sv
// rr_pick: combinational masked priority encoder; returns the first set request
// found when scanning upward (with wrap) from the start index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // scan candidates in wrap order; the first hit latches idx and found
  always_comb begin
    idx    = {IDX_W{1'b0}};
    found  = 1'b0;
    cand_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = IDX_W'((int'(start) + k) % N_REQ);
      hit_s  = !found && req[cand_s];
      idx    = hit_s ? cand_s : idx;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/interface_arbiter.sv
// interface_arbiter: burst arbiter in front of the interface data port.
// Define INTERFACE_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module interface_arbiter
  import interface_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);

`ifdef INTERFACE_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] GRANT_RST = IDX_W'(N_REQ - 1);
`else
  localparam logic [IDX_W-1:0] GRANT_RST = {IDX_W{1'b0}};
`endif
  // counter holds beats already taken, so the final beat is seen at MAX_BURST-1
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_t              state_r, state_nxt_s;
  logic [IDX_W-1:0]        grant_id_r, start_s, pick_idx_s;
  logic                    pick_found_s, grant_s, accept_s;
  logic [BEAT_CNT_W-1:0]   beat_cnt_r;
  logic [DATA_W-1:0]       data_out_r, word_s;
  logic                    data_valid_r;
  logic [N_REQ-1:0]        req_ready_s;

  // search start: one past the last grant, or always requester 0
  always_comb begin
`ifdef INTERFACE_ARB_ROUND_ROBIN_EN
    start_s = (grant_id_r == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : grant_id_r + IDX_W'(1);
`else
    start_s = {IDX_W{1'b0}};
`endif
  end

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_valid),
    .start (start_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // select the granted requester's word
  always_comb begin
    word_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      word_s = (grant_id_r == IDX_W'(i)) ? req_data[i*DATA_W +: DATA_W] : word_s;
    end
  end

  // next-state, ready and accept decode
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = {N_REQ{1'b0}};
    accept_s    = 1'b0;
    grant_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          grant_s     = 1'b1;
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        req_ready_s[grant_id_r] = 1'b1;
        if (req_valid[grant_id_r]) begin
          accept_s = 1'b1;
          if (req_last[grant_id_r] || (beat_cnt_r == LAST_BEAT)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = BURST;
          end
        end else begin
          // a silent owner gives the port back rather than holding it
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, grant pointer and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      grant_id_r <= GRANT_RST;
      beat_cnt_r <= {BEAT_CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        grant_id_r <= pick_idx_s;
        beat_cnt_r <= {BEAT_CNT_W{1'b0}};
      end else if (accept_s) begin
        grant_id_r <= grant_id_r;
        beat_cnt_r <= (beat_cnt_r == {BEAT_CNT_W{1'b1}}) ? beat_cnt_r : beat_cnt_r + BEAT_CNT_W'(1);
      end else begin
        grant_id_r <= grant_id_r;
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  // registered output stage toward interface
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
    end else begin
      data_out_r   <= accept_s ? word_s : {DATA_W{1'b0}};
      data_valid_r <= accept_s;
    end
  end

  assign req_ready  = req_ready_s;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign grant_id   = grant_id_r;
  assign busy       = (state_r == BURST);

endmodule

// File: tb/tb_interface_arbiter.sv
// Self-checking bench for interface_arbiter: vector table, directed corner
// sequences and random traffic checked against a transaction-level model.
module tb_interface_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 8;
  localparam int IW = 2;
`ifdef INTERFACE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int GID_RST = RR ? N - 1 : 0;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [IW-1:0] grant_id;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  interface_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .data_out(data_out),
    .data_valid(data_valid), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference model: who owns the port (-1 = nobody), last winner, beats taken
  int            m_owner, m_last_grant, m_beats;
  logic [DW-1:0] m_dout;
  logic          m_dv;

  function automatic void model_reset();
    m_owner = -1; m_last_grant = GID_RST; m_beats = 0; m_dout = '0; m_dv = 1'b0;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_owner >= 0) r[m_owner] = 1'b1;
    return r;
  endfunction

  function automatic void model_step(input logic [N-1:0] v, input logic [N-1:0] l,
                                     input logic [N*DW-1:0] d);
    int start, c;
    m_dout = '0; m_dv = 1'b0;
    if (m_owner < 0) begin
      start = RR ? (m_last_grant + 1) % N : 0;
      for (int k = 0; k < N; k++) begin
        c = (start + k) % N;
        if (m_owner < 0 && v[c]) begin
          m_owner = c; m_last_grant = c; m_beats = 0;
        end
      end
    end else if (v[m_owner]) begin
      m_dout = d[m_owner*DW +: DW];
      m_dv = 1'b1;
      m_beats++;
      if (l[m_owner] || m_beats == MB) m_owner = -1;
    end else begin
      m_owner = -1;
    end
  endfunction

  function automatic logic [N*DW-1:0] put(input int slot, input logic [DW-1:0] w);
    logic [N*DW-1:0] d;
    d = '0;
    d[slot*DW +: DW] = w;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one cycle, entered and left at a negedge; all outputs compared to the model
  task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                           input logic [N*DW-1:0] d);
    req_valid = v; req_last = l; req_data = d;
    #1;
    chk("req_ready", req_ready, model_ready());
    model_step(v, l, d);
    @(posedge clk);
    @(negedge clk);
    chk("data_out", data_out, m_dout);
    chk("data_valid", data_valid, m_dv);
    chk("grant_id", grant_id, m_last_grant);
    chk("busy", busy, m_owner >= 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic [DW-1:0] w;
    logic [N-1:0]  e_ready;
    logic          e_dv;
    logic [DW-1:0] e_dout;
    logic [IW-1:0] e_gid;
    logic          e_busy;
  } vec_t;

  vec_t tbl[7];
  int   sent[N];
  int   got, run_len;
  int   runs[$];
  logic [IW-1:0] grants[$];
  logic prev_busy;
  logic [N-1:0] v, l;
  logic [N*DW-1:0] d;

  initial begin
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    model_reset();

    // reset held with random requests: nothing may be granted or emitted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = N'($urandom); req_last = N'($urandom);
      req_data = {$urandom, $urandom};
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_gid", grant_id, GID_RST);
    end
    @(negedge clk);
    req_valid = '0; req_last = '0; req_data = '0;
    rst = 1'b1;
    model_reset();

    // requester 2 sends 1,2,3 then re-requests once and goes silent
    tbl[0] = '{4'b0100, 4'b0000, 16'd1, 4'b0000, 1'b0, 16'd0, 2'd2, 1'b1};
    tbl[1] = '{4'b0100, 4'b0000, 16'd1, 4'b0100, 1'b1, 16'd1, 2'd2, 1'b1};
    tbl[2] = '{4'b0100, 4'b0000, 16'd2, 4'b0100, 1'b1, 16'd2, 2'd2, 1'b1};
    tbl[3] = '{4'b0100, 4'b0100, 16'd3, 4'b0100, 1'b1, 16'd3, 2'd2, 1'b0};
    tbl[4] = '{4'b0100, 4'b0000, 16'd4, 4'b0000, 1'b0, 16'd0, 2'd2, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, 16'd0, 4'b0100, 1'b0, 16'd0, 2'd2, 1'b0};
    tbl[6] = '{4'b0000, 4'b0000, 16'd0, 4'b0000, 1'b0, 16'd0, 2'd2, 1'b0};
    for (int i = 0; i < 7; i++) begin
      req_valid = tbl[i].v; req_last = tbl[i].l; req_data = put(2, tbl[i].w);
      #1;
      chk("tbl_ready", req_ready, tbl[i].e_ready);
      model_step(tbl[i].v, tbl[i].l, put(2, tbl[i].w));
      @(posedge clk);
      @(negedge clk);
      chk("tbl_dout", data_out, tbl[i].e_dout);
      chk("tbl_dv", data_valid, tbl[i].e_dv);
      chk("tbl_gid", grant_id, tbl[i].e_gid);
      chk("tbl_busy", busy, tbl[i].e_busy);
    end

    // burst cap: requester 0 streams 12 words without last
    got = 0; run_len = 0; sent[0] = 0;
    for (int c = 0; c < 40; c++) begin
      logic acc;
      v = (sent[0] < 12) ? 4'b0001 : 4'b0000;
      acc = (m_owner == 0) && v[0];
      run_cycle(v, 4'b0000, put(0, DW'(sent[0] + 1)));
      if (acc) sent[0]++;
      if (data_valid) begin
        got++; run_len++;
        chk("cap_order", data_out, got);
      end else if (run_len > 0) begin
        runs.push_back(run_len); run_len = 0;
      end
    end
    chk("cap_words", got, 12);
    chk("cap_runs", runs.size(), 2);
    if (runs.size() == 2) begin
      chk("cap_run0", runs[0], MB);
      chk("cap_run1", runs[1], 12 - MB);
    end

    // all four requesting, 2-word bursts
    do_reset();
    for (int i = 0; i < N; i++) sent[i] = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      int o;
      o = m_owner;
      for (int i = 0; i < N; i++) l[i] = sent[i][0];
      run_cycle(4'b1111, l, {$urandom, $urandom});
      if (o >= 0) sent[o]++;
      if (busy && !prev_busy) grants.push_back(grant_id);
      prev_busy = busy;
    end
    chk("rr_count", grants.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr_order", grants[i], RR ? (i % N) : 0);

    // valid drop: owner 1 goes quiet after one word, waiting requester 3 wins
    do_reset();
    run_cycle(4'b0010, 4'b0000, put(1, 16'hA001));
    run_cycle(4'b1010, 4'b0000, put(1, 16'hA001) | put(3, 16'hB001));
    run_cycle(4'b1000, 4'b0000, put(3, 16'hB001));
    chk("drop_dv", data_valid, 0);
    run_cycle(4'b1000, 4'b0000, put(3, 16'hB001));
    chk("drop_gid", grant_id, 3);
    run_cycle(4'b1000, 4'b1000, put(3, 16'hB001));
    chk("drop_word", data_out, 16'hB001);

    // reset asserted during beat 3 clears outputs at once
    do_reset();
    run_cycle(4'b0001, 4'b0000, put(0, 16'd1));
    run_cycle(4'b0001, 4'b0000, put(0, 16'd1));
    run_cycle(4'b0001, 4'b0000, put(0, 16'd2));
    req_data = put(0, 16'd3);
    #2 rst = 1'b0;
    #1;
    chk("mrst_ready", req_ready, 0);
    chk("mrst_dv", data_valid, 0);
    chk("mrst_dout", data_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_gid", grant_id, GID_RST);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_cycle(4'b0101, 4'b0000, put(0, 16'h55) | put(2, 16'h66));
    chk("mrst_regrant", grant_id, 0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        l[i] = ($urandom_range(0, 4) == 0);
      end
      d = {$urandom, $urandom};
      run_cycle(v, l, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
